// File: rtl/denoise_pkg.sv
// Shared types, sizing helpers and default parameter values for the stream_denoise block.
package denoise_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        RUN,
        FLUSH
    } state_t;

    localparam int DEF_N_SIZE     = 5;
    localparam int DEF_COLORS     = 3;
    localparam int DEF_IMG_WIDTH  = 640;
    localparam int DEF_IMG_HEIGHT = 480;

    // Width that can hold any neighbour count 0..n*n without overflow.
    function automatic int calc_tw(input int n);
        return $clog2(n * n + 1);
    endfunction

    function automatic int calc_c(input int n);
        return n / 2;
    endfunction

endpackage

// File: rtl/stream_denoise_if.sv
// Pixel stream in/out bundle for stream_denoise; slave is the filter side, master the source/sink side.
interface stream_denoise_if
    import denoise_pkg::*;
#(
    parameter int COLORS = DEF_COLORS,
    parameter int TW     = calc_tw(DEF_N_SIZE)
);
    logic              in_valid;
    logic              in_ready;
    logic              in_sof;
    logic [COLORS-1:0] in_pixel;
    logic [TW-1:0]     n_threshold;
    logic              out_valid;
    logic              out_sof;
    logic [COLORS-1:0] out_pixel;

    modport master (
        output in_valid, in_sof, in_pixel, n_threshold,
        input  in_ready, out_valid, out_sof, out_pixel
    );

    modport slave (
        input  in_valid, in_sof, in_pixel, n_threshold,
        output in_ready, out_valid, out_sof, out_pixel
    );
endinterface

// File: rtl/denoise_linebuf.sv
// Column-addressed delay of N_SIZE-1 lines: one word per column, row 0 holds the most recent line.
module denoise_linebuf #(
    parameter int N_SIZE    = 5,
    parameter int COLORS    = 3,
    parameter int IMG_WIDTH = 640,
    parameter int AW        = $clog2(IMG_WIDTH)
) (
    input  logic                           clk,
    input  logic                           we,
    input  logic [AW-1:0]                  addr,
    input  logic [COLORS-1:0]              wdata,
    output logic [N_SIZE-2:0][COLORS-1:0]  rdata
);

    logic [N_SIZE-2:0][COLORS-1:0] mem [IMG_WIDTH];

    assign rdata = mem[addr];

    // Each column word ages by one line: the new pixel enters row 0, the oldest row drops out.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= {rdata[N_SIZE-3:0], wdata};
        end
    end

endmodule

// File: rtl/stream_denoise.sv
// Binary-mask neighbourhood-count denoiser over a raster pixel stream.
// Optional build macro DENOISE_CENTER_GATE_EN: an output bit also requires its centre pixel bit set.
module stream_denoise
    import denoise_pkg::*;
#(
    parameter int N_SIZE     = DEF_N_SIZE,
    parameter int COLORS     = DEF_COLORS,
    parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
    parameter int IMG_HEIGHT = DEF_IMG_HEIGHT
) (
    input logic              clk,
    input logic              rst_n,
    stream_denoise_if.slave  bus
);

    localparam int C   = calc_c(N_SIZE);
    localparam int TW  = calc_tw(N_SIZE);
    localparam int PXW = $clog2(IMG_WIDTH);
    localparam int PYW = $clog2(IMG_HEIGHT + C + 1);

    state_t state, state_nx;
    logic ready, proc, start, emit;

    logic [PXW-1:0]    px, pos_x;
    logic [PYW-1:0]    py, pos_y;
    logic [TW-1:0]     thr_q;
    logic [COLORS-1:0] new_pix;

    logic [N_SIZE-2:0][COLORS-1:0] lb_rd;
    logic [COLORS-1:0] win_p0 [N_SIZE][N_SIZE-1];
    logic [COLORS-1:0] nwin   [N_SIZE][N_SIZE];

    logic signed [31:0] cx, cy;
    logic [N_SIZE-1:0]  row_ok, col_ok;
    logic [COLORS-1:0]  pix_nx;
    logic               sof_nx;

    logic              vld_p1, sof_p1;
    logic [COLORS-1:0] pix_p1;

    function automatic logic [TW-1:0] hit_count(input logic [N_SIZE*N_SIZE-1:0] hits);
        logic [TW-1:0] n;
        n = '0;
        for (int k = 0; k < N_SIZE * N_SIZE; k++) begin
            n = n + TW'(hits[k]);
        end
        return n;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        ready    = 1'b1;
        proc     = 1'b0;
        start    = 1'b0;
        emit     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.in_valid && bus.in_sof) begin
                    proc     = 1'b1;
                    start    = 1'b1;
                    state_nx = FILL;
                end
            end
            FILL: begin
                if (bus.in_valid) begin
                    proc = 1'b1;
                    if (bus.in_sof) begin
                        start = 1'b1;
                    end else if (px == PXW'(C - 1) && py == PYW'(C)) begin
                        state_nx = RUN;
                    end
                end
            end
            RUN: begin
                if (bus.in_valid) begin
                    proc = 1'b1;
                    if (bus.in_sof) begin
                        start    = 1'b1;
                        state_nx = FILL;
                    end else begin
                        emit = 1'b1;
                        if (px == PXW'(IMG_WIDTH - 1) && py == PYW'(IMG_HEIGHT - 1)) begin
                            state_nx = FLUSH;
                        end
                    end
                end
            end
            FLUSH: begin
                ready = 1'b0;
                proc  = 1'b1;
                emit  = 1'b1;
                if (px == PXW'(C - 1) && py == PYW'(IMG_HEIGHT + C)) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign bus.in_ready = ready;

    // A start-of-frame pixel is processed as raster position (0,0) regardless of the counters.
    assign pos_x   = start ? '0 : px;
    assign pos_y   = start ? '0 : py;
    assign new_pix = (state == FLUSH) ? '0 : bus.in_pixel;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            px    <= '0;
            py    <= '0;
            thr_q <= '0;
        end else begin
            if (proc) begin
                if (pos_x == PXW'(IMG_WIDTH - 1)) begin
                    px <= '0;
                    py <= pos_y + PYW'(1);
                end else begin
                    px <= pos_x + PXW'(1);
                    py <= pos_y;
                end
            end
            if (start) thr_q <= bus.n_threshold;
        end
    end

    denoise_linebuf #(
        .N_SIZE    (N_SIZE),
        .COLORS    (COLORS),
        .IMG_WIDTH (IMG_WIDTH),
        .AW        (PXW)
    ) u_linebuf (
        .clk   (clk),
        .we    (proc),
        .addr  (pos_x),
        .wdata (new_pix),
        .rdata (lb_rd)
    );

    // Stage p0: window = retained N-1 columns plus the column arriving with this pixel.
    always_comb begin
        for (int i = 0; i < N_SIZE; i++) begin
            for (int j = 0; j < N_SIZE - 1; j++) begin
                nwin[i][j] = win_p0[i][j];
            end
        end
        for (int i = 0; i < N_SIZE - 1; i++) begin
            nwin[i][N_SIZE-1] = lb_rd[N_SIZE-2-i];
        end
        nwin[N_SIZE-1][N_SIZE-1] = new_pix;
    end

    always_ff @(posedge clk) begin
        if (proc) begin
            for (int i = 0; i < N_SIZE; i++) begin
                for (int j = 0; j < N_SIZE - 1; j++) begin
                    win_p0[i][j] <= nwin[i][j+1];
                end
            end
        end
    end

    // Centre lags the input by C lines and C pixels; near the left edge it still sits on the previous line.
    always_comb begin
        if (pos_x >= PXW'(C)) begin
            cx = $signed(32'(pos_x)) - C;
            cy = $signed(32'(pos_y)) - C;
        end else begin
            cx = $signed(32'(pos_x)) - C + IMG_WIDTH;
            cy = $signed(32'(pos_y)) - C - 1;
        end
        for (int i = 0; i < N_SIZE; i++) begin
            row_ok[i] = (cy + i - C >= 0) && (cy + i - C < IMG_HEIGHT);
            col_ok[i] = (cx + i - C >= 0) && (cx + i - C < IMG_WIDTH);
        end
        sof_nx = (cx == 0) && (cy == 0);
    end

    always_comb begin : count_blk
        logic [N_SIZE*N_SIZE-1:0] hits;
        hits   = '0;
        pix_nx = '0;
        for (int c = 0; c < COLORS; c++) begin
            for (int i = 0; i < N_SIZE; i++) begin
                for (int j = 0; j < N_SIZE; j++) begin
                    hits[i*N_SIZE+j] = row_ok[i] & col_ok[j] & nwin[i][j][c];
                end
            end
`ifdef DENOISE_CENTER_GATE_EN
            pix_nx[c] = (hit_count(hits) >= thr_q) & nwin[C][C][c];
`else
            pix_nx[c] = (hit_count(hits) >= thr_q);
`endif
        end
    end

    // Stage p1: registered output pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
            sof_p1 <= 1'b0;
            pix_p1 <= '0;
        end else begin
            vld_p1 <= emit;
            sof_p1 <= emit & sof_nx;
            if (emit) pix_p1 <= pix_nx;
        end
    end

    assign bus.out_valid = vld_p1;
    assign bus.out_sof   = sof_p1;
    assign bus.out_pixel = pix_p1;

endmodule

// File: tb/tb_stream_denoise.sv
// Directed bench for stream_denoise (3x3 window, 2 colours, 8x4 image) against a frame-level model.
module tb_stream_denoise;
    import denoise_pkg::*;

    localparam int N    = 3;
    localparam int COLS = 2;
    localparam int W    = 8;
    localparam int H    = 4;
    localparam int C    = N / 2;
    localparam int TW   = calc_tw(N);
    localparam int D    = C * W + C;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    stream_denoise_if #(.COLORS(COLS), .TW(TW)) bus ();

    stream_denoise #(
        .N_SIZE     (N),
        .COLORS     (COLS),
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic            sof;
        logic [COLS-1:0] pix;
        int              x;
        int              y;
    } exp_t;

    exp_t            exp_q[$];
    logic [COLS-1:0] img [H][W];
    int checks = 0;
    int errors = 0;
    int pulses = 0;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    // Direct neighbourhood count over the stored frame, zero outside the image.
    function automatic logic [COLS-1:0] model_pix(input int x, input int y, input int thr);
        logic [COLS-1:0] r;
        r = '0;
        for (int c = 0; c < COLS; c++) begin
            int cnt;
            cnt = 0;
            for (int dy = -C; dy <= C; dy++) begin
                for (int dx = -C; dx <= C; dx++) begin
                    if (x + dx >= 0 && x + dx < W && y + dy >= 0 && y + dy < H)
                        cnt += int'(img[y+dy][x+dx][c]);
                end
            end
            r[c] = (cnt >= thr);
`ifdef DENOISE_CENTER_GATE_EN
            r[c] = r[c] & img[y][x][c];
`endif
        end
        return r;
    endfunction

    task automatic set_ones();
        for (int y = 0; y < H; y++) for (int x = 0; x < W; x++) img[y][x] = 2'b11;
    endtask

    task automatic set_single();
        for (int y = 0; y < H; y++) for (int x = 0; x < W; x++) img[y][x] = 2'b00;
        img[2][3] = 2'b01;
    endtask

    task automatic set_pattern(input int k);
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                img[y][x] = COLS'((x * 3 + y * 5 + k) % 4);
    endtask

    task automatic expect_frame(input int n, input int thr);
        exp_t e;
        for (int k = 0; k < n; k++) begin
            e.x   = k % W;
            e.y   = k / W;
            e.sof = (k == 0);
            e.pix = model_pix(e.x, e.y, thr);
            exp_q.push_back(e);
        end
    endtask

    task automatic drive_pix(input logic sof, input logic [COLS-1:0] pix, input int thr, input bit gaps);
        int b;
        if (gaps) begin
            for (int g = 0; g < 3 && $urandom_range(0, 1) == 1; g++) begin
                bus.in_valid = 1'b0;
                @(negedge clk);
            end
        end
        bus.in_valid    = 1'b1;
        bus.in_sof      = sof;
        bus.in_pixel    = pix;
        bus.n_threshold = TW'(thr);
        b = 0;
        while (!bus.in_ready && b < 50) begin
            @(negedge clk);
            b++;
        end
        if (b == 50) begin
            checks++;
            errors++;
            $display("FAIL in_ready_timeout: in_ready=%0d, required 1", bus.in_ready);
        end
        @(negedge clk);
    endtask

    task automatic drive_frame(input int n_pix, input int thr_sof, input int thr_rest, input bit gaps);
        for (int k = 0; k < n_pix; k++)
            drive_pix(k == 0, img[k/W][k%W], (k == 0) ? thr_sof : thr_rest, gaps);
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int exp_pulses);
        int b;
        b = 0;
        while ((exp_q.size() != 0 || !bus.in_ready) && b < 300) begin
            @(negedge clk);
            b++;
        end
        check({name, "_drain"}, exp_q.size(), 0);
        repeat (4) @(negedge clk);
        check({name, "_pulses"}, pulses, exp_pulses);
        pulses = 0;
    endtask

    always @(negedge clk) begin : compare
        exp_t e;
        if (rst_n && bus.out_valid) begin
            pulses++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got sof=%0d pix=%0d, required no output",
                         bus.out_sof, bus.out_pixel);
            end else begin
                e = exp_q.pop_front();
                check($sformatf("out(%0d,%0d){sof,pix}", e.x, e.y),
                      int'({bus.out_sof, bus.out_pixel}), int'({e.sof, e.pix}));
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time exceeded");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid    = 1'b0;
        bus.in_sof      = 1'b0;
        bus.in_pixel    = '0;
        bus.n_threshold = '0;

        // Hand-computed pins on the model itself
        set_ones();
        check("model_corner_t4", int'(model_pix(0, 0, 4)), 3);
        check("model_corner_t5", int'(model_pix(0, 0, 5)), 0);
        check("model_edge_t6",   int'(model_pix(3, 0, 6)), 3);
        check("model_edge_t7",   int'(model_pix(3, 0, 7)), 0);
        check("model_inner_t9",  int'(model_pix(3, 1, 9)), 3);
        set_single();
        check("model_single_ctr", int'(model_pix(3, 2, 1)), 1);
`ifdef DENOISE_CENTER_GATE_EN
        check("model_single_nbr", int'(model_pix(2, 1, 1)), 0);
`else
        check("model_single_nbr", int'(model_pix(2, 1, 1)), 1);
`endif
        check("model_single_far", int'(model_pix(5, 3, 1)), 0);

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_out_valid", int'(bus.out_valid), 0);
        check("rst_out_sof",   int'(bus.out_sof), 0);
        check("rst_out_pixel", int'(bus.out_pixel), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_rst", int'(bus.in_ready), 1);

        // All ones, threshold 9: only interior survives
        set_ones();
        expect_frame(W * H, 9);
        drive_frame(W * H, 9, 9, 1'b0);
        wait_idle("ones_t9", W * H);

        // Pixels without sof in IDLE are dropped
        for (int k = 0; k < 3; k++) drive_pix(1'b0, 2'b11, 1, 1'b0);
        bus.in_valid = 1'b0;
        repeat (5) @(negedge clk);
        check("idle_discard_pulses", pulses, 0);
        check("idle_ready", int'(bus.in_ready), 1);
        pulses = 0;

        // Isolated pixel
        set_single();
        expect_frame(W * H, 2);
        drive_frame(W * H, 2, 2, 1'b0);
        wait_idle("single_t2", W * H);
        expect_frame(W * H, 1);
        drive_frame(W * H, 1, 1, 1'b0);
        wait_idle("single_t1", W * H);

        // Pattern with random input gaps
        set_pattern(0);
        expect_frame(W * H, 3);
        drive_frame(W * H, 3, 3, 1'b1);
        wait_idle("gaps_t3", W * H);

        // Frame aborted by a new sof at input index 20
        set_pattern(1);
        expect_frame(20 - D, 4);
        drive_frame(20, 4, 4, 1'b0);
        set_ones();
        expect_frame(W * H, 6);
        drive_frame(W * H, 6, 6, 1'b1);
        wait_idle("abort", (20 - D) + W * H);

        // Reset in the middle of RUN
        set_pattern(2);
        expect_frame(15 - D, 5);
        drive_frame(15, 5, 5, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_out_valid", int'(bus.out_valid), 0);
        check("midrst_out_pixel", int'(bus.out_pixel), 0);
        check("midrst_out_sof",   int'(bus.out_sof), 0);
        check("midrst_drained",   exp_q.size(), 0);
        check("midrst_pulses",    pulses, 15 - D);
        pulses = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_ready", int'(bus.in_ready), 1);
        set_pattern(3);
        expect_frame(W * H, 5);
        drive_frame(W * H, 5, 5, 1'b0);
        wait_idle("after_rst", W * H);

        // Threshold 0 latched at sof; later threshold values are ignored
        set_pattern(1);
        expect_frame(W * H, 0);
        drive_frame(W * H, 0, 9, 1'b1);
        wait_idle("thr0", W * H);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/stream_denoise.md
STREAM_DENOISE -- requirements
Module: stream_denoise

Interface
REQ-001 The block SHALL have parameter N_SIZE, default 5, odd neighbourhood edge length (3..9); C = N_SIZE/2.
REQ-002 The block SHALL have parameter COLORS, default 3, number of independent 1-bit colour masks per pixel.
REQ-003 The block SHALL have parameter IMG_WIDTH, default 640, active pixels per line.
REQ-004 The block SHALL have parameter IMG_HEIGHT, default 480, active lines per frame.
REQ-005 The block SHALL have port clk, input, 1, the single clock; all state SHALL be on its rising edge.
REQ-006 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-007 The block SHALL have port in_valid, input, 1, input pixel present.
REQ-008 The block SHALL have port in_ready, output, 1, a pixel is accepted when in_valid and in_ready are both high.
REQ-009 The block SHALL have port in_sof, input, 1, the accepted pixel is (0,0) of a frame.
REQ-010 The block SHALL have port in_pixel, input, COLORS, colour mask bits.
REQ-011 The block SHALL have port n_threshold, input, TW=$clog2(N_SIZE*N_SIZE+1), minimum neighbour count.
REQ-012 The block SHALL have port out_valid, output, 1, output pixel present (single-cycle pulse, no backpressure).
REQ-013 The block SHALL have port out_sof, output, 1, the output pixel is (0,0).
REQ-014 The block SHALL have port out_pixel, output, COLORS, denoised mask bits.

Function
REQ-015 The block SHALL buffer N_SIZE-1 lines of IMG_WIDTH x COLORS bits and an N_SIZE x N_SIZE window shift register, raster order.
REQ-016 Window positions outside the image (row/col < 0 or >= size) SHALL read as 0; no wrap across line or frame edges.
REQ-017 For each colour c, out_pixel[c] SHALL be 1 iff the count of set bits c in the window centred on (x,y) >= threshold latched at in_sof; threshold 0 gives all ones.
REQ-018 The count adder SHALL be TW bits wide and never overflow.
REQ-019 FSM states SHALL be IDLE, FILL, RUN, FLUSH.
REQ-020 IDLE: in_ready=1; pixels without in_sof are discarded; accepted in_sof -> FILL.
REQ-021 FILL: accept until input index reaches C*IMG_WIDTH+C, then -> RUN; no out_valid in FILL.
REQ-022 RUN: each accepted pixel yields out_valid exactly one cycle later for output (x,y) centred C rows, C cols behind input; after last input pixel accepted -> FLUSH.
REQ-023 FLUSH: in_ready=0; internally inject C*IMG_WIDTH+C zero pixels at one per cycle, emitting the remaining outputs; then -> IDLE.
REQ-024 Exactly IMG_WIDTH*IMG_HEIGHT out_valid pulses SHALL be produced per frame; out_sof high only with the first.
REQ-025 in_sof accepted in FILL or RUN SHALL abort the current frame (no further outputs from it) and restart FILL with that pixel as (0,0).
REQ-026 in_valid gaps SHALL be tolerated in any state; state and counters hold while no pixel is accepted.

Reset
REQ-027 While rst_n=0: state IDLE, counters 0, out_valid=0, out_sof=0, out_pixel=0, in_ready=0 is not required -- in_ready SHALL be 1 from the first edge after release.
REQ-028 Line buffer RAM SHALL not require reset; stale contents are masked by REQ-016.
REQ-029 Reset asserted mid-frame SHALL drop the frame; the next in_sof starts cleanly.

Configuration
REQ-030 With DENOISE_CENTER_GATE_EN defined, out_pixel[c] SHALL additionally require the centre pixel bit c to be 1.
REQ-031 Without DENOISE_CENTER_GATE_EN, the centre pixel SHALL be counted only like any other window pixel.

Structure
REQ-032 Package denoise_pkg SHALL hold the state enum, TW/C computation functions, and default parameter constants.
REQ-033 Sub-module denoise_linebuf (N_SIZE-1 line delay, column-addressed, one write+read per accepted pixel) SHALL be instantiated once.

Verification (N_SIZE=3, COLORS=2, 8x4 image unless noted)
REQ-034 All-ones frame, threshold 9 -> interior outputs 2'b11, corners 2'b00 (count 4), edges 2'b00 (count 6); 32 pulses.
REQ-035 Single isolated pixel c0 at (3,2), threshold 2 -> all outputs 0; threshold 1 -> 3x3 block around (3,2) is 2'b01 (with DENOISE_CENTER_GATE_EN only (3,2)).
REQ-036 Random in_valid gaps (50%) -> output sequence identical to gap-free reference model.
REQ-037 in_sof re-asserted at input index 20 -> no output from first frame beyond already-emitted ones; second frame yields 32 pulses, first with out_sof.
REQ-038 rst_n pulsed low during RUN -> outputs 0 immediately, IDLE; subsequent frame correct.
REQ-039 threshold 0 -> all 32 outputs 2'b11; threshold change mid-frame ignored until next in_sof.
